// File: rtl/cga_composite_ctrl.sv
// CGA composite encoder sequencer: clock strobes from the 28.636 MHz clock, plus a shadowed mode register
// that updates on vsync. The optional line-count timeout apply is enabled by defining CGA_COMP_TIMEOUT_EN.
module cga_composite_ctrl #(
    parameter logic [9:0] TIMEOUT_LINES = 10'd525,
    parameter logic [1:0] MODE_RESET    = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       hsync,
    input  logic       vsync,
    output logic       hclk_en,
    output logic       lclk_en,
    output logic       clk_3m58,
    output logic       bw_mode,
    output logic       hires,
    output logic       mode_pending,
    output logic       apply_pulse
);
    typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

    state_t     state_q, state_d;
    logic [3:0] div_cnt_q;
    logic       hclk_en_q, lclk_en_q, clk_3m58_q;
    logic [1:0] mode_q, shadow_q, shadow_d;   // {hires, bw_mode}
    logic       pending_q, apply_q;
    logic       hsync_q, vsync_q;
    logic       hs_rise, vs_rise, timeout;
    logic [1:0] wr_mode;
    logic       unused_bits;

    assign hs_rise = hsync & ~hsync_q;
    assign vs_rise = vsync & ~vsync_q;
    assign wr_mode = {wr_data[0], wr_data[2]};

`ifdef CGA_COMP_TIMEOUT_EN
    logic [9:0] line_cnt_q, line_cnt_d;
    assign timeout     = hs_rise && (line_cnt_q == TIMEOUT_LINES - 10'd1);
    assign unused_bits = ^{wr_data[7:3], wr_data[1]};
`else
    assign timeout     = 1'b0;
    assign unused_bits = ^{wr_data[7:3], wr_data[1], hs_rise, TIMEOUT_LINES};
`endif

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
`ifdef CGA_COMP_TIMEOUT_EN
        line_cnt_d = line_cnt_q;
`endif
        case (state_q)
            IDLE, APPLY: begin
                state_d = IDLE;
                if (wr_en) begin
                    shadow_d = wr_mode;
                    state_d  = PENDING;
`ifdef CGA_COMP_TIMEOUT_EN
                    line_cnt_d = '0;
`endif
                end
            end
            PENDING: begin
                if (wr_en) shadow_d = wr_mode;
`ifdef CGA_COMP_TIMEOUT_EN
                if (hs_rise && line_cnt_q != TIMEOUT_LINES - 10'd1)
                    line_cnt_d = line_cnt_q + 10'd1;
`endif
                if (vs_rise || timeout) state_d = APPLY;
            end
            default: state_d = IDLE;
        endcase
    end

    // Mode and apply strobe update on the APPLY decision, so they are visible during APPLY itself;
    // using shadow_d lets a write coinciding with vs_rise be applied at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            hclk_en_q  <= 1'b0;
            lclk_en_q  <= 1'b0;
            clk_3m58_q <= 1'b0;
            mode_q     <= MODE_RESET;
            shadow_q   <= MODE_RESET;
            pending_q  <= 1'b0;
            apply_q    <= 1'b0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
`ifdef CGA_COMP_TIMEOUT_EN
            line_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_q + 4'd1;
            hclk_en_q  <= div_cnt_q[0];
            clk_3m58_q <= div_cnt_q[2];
            lclk_en_q  <= mode_q[1] ? (div_cnt_q[2:0] == 3'd7) : (div_cnt_q == 4'd15);
            shadow_q   <= shadow_d;
            pending_q  <= (state_d != IDLE);
            apply_q    <= (state_d == APPLY);
            if (state_d == APPLY) mode_q <= shadow_d;
            hsync_q    <= hsync;
            vsync_q    <= vsync;
`ifdef CGA_COMP_TIMEOUT_EN
            line_cnt_q <= line_cnt_d;
`endif
        end
    end

    assign hclk_en      = hclk_en_q;
    assign lclk_en      = lclk_en_q;
    assign clk_3m58     = clk_3m58_q;
    assign hires        = mode_q[1];
    assign bw_mode      = mode_q[0];
    assign mode_pending = pending_q;
    assign apply_pulse  = apply_q;
endmodule
